// File: rtl/sfifo_bram_pf_gen_pkg.sv
// rtl/sfifo_bram_pf_gen_pkg.sv - shared types and helpers for the prefetching BRAM FIFO
package sfifo_bram_pf_gen_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  // Number of BRAM reads still travelling down the (at most 2-deep) valid pipe.
  function automatic logic [1:0] inflight_cnt(input logic [1:0] vld);
    return {1'b0, vld[0]} + {1'b0, vld[1]};
  endfunction

endpackage

// File: rtl/sfifo_bram_pf_gen_if.sv
// rtl/sfifo_bram_pf_gen_if.sv - push/pop/status bundle of the prefetching BRAM FIFO
interface sfifo_bram_pf_gen_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 15
);
  logic [WIDTH-1:0] din;
  logic             wr;
  logic             rd;
  logic             flush;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic             afull;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             udf;

  modport master (
    output din, wr, rd, flush,
    input  dout, empty, full, afull, count, ovf, udf
  );

  modport slave (
    input  din, wr, rd, flush,
    output dout, empty, full, afull, count, ovf, udf
  );
endinterface

// File: rtl/sfifo_bram_gen.sv
// rtl/sfifo_bram_gen.sv - BRAM-backed FIFO store with RD_LAT-cycle registered read and valid pipe
module sfifo_bram_gen
  import sfifo_bram_pf_gen_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int DEPTH_NBITS = 12,
  parameter int RD_LAT      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic [1:0]       inflight,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_NBITS;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH_NBITS-1:0] wptr;
  logic [DEPTH_NBITS-1:0] rptr;
  logic [DEPTH_NBITS:0]   occ;
  logic [WIDTH-1:0]       rd_d1;
  logic [WIDTH-1:0]       rd_d2;
  logic [1:0]             vld;

  // Storage and read data path carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
    if (rd) rd_d1 <= mem[rptr];
    rd_d2 <= rd_d1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      vld  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      vld  <= '0;
    end else begin
      if (wr) wptr <= wptr + DEPTH_NBITS'(1);
      if (rd) rptr <= rptr + DEPTH_NBITS'(1);
      occ <= occ + {{DEPTH_NBITS{1'b0}}, wr} - {{DEPTH_NBITS{1'b0}}, rd};
      vld <= {vld[0] & (RD_LAT == 2), rd};
    end
  end

  assign rdata    = (RD_LAT == 2) ? rd_d2 : rd_d1;
  assign rvalid   = vld[RD_LAT-1];
  assign inflight = inflight_cnt(vld);
  assign full     = occ[DEPTH_NBITS];
  assign empty    = (occ == '0);

endmodule

// File: rtl/sfifo_bram_pf_gen.sv
// rtl/sfifo_bram_pf_gen.sv - show-ahead FIFO: BRAM store feeding a small register prefetch stage
module sfifo_bram_pf_gen
  import sfifo_bram_pf_gen_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int DEPTH_NBITS = 12,
  parameter int PF_NBITS    = 2,
  parameter int RD_LAT      = 1,
  parameter int AFULL_TH    = (1 << DEPTH_NBITS) - 16
) (
  input logic               clk,
  input logic               rst,
  sfifo_bram_pf_gen_if.slave bus
);
  localparam int PF_DEPTH = 1 << PF_NBITS;
  localparam int CNT_W    = DEPTH_NBITS + PF_NBITS + 1;

  logic                wr_acc;
  logic                rd_acc;
  logic                issue;
  logic                bram_full;
  logic                bram_empty;
  logic                pf_wr;
  logic [WIDTH-1:0]    bram_rdata;
  logic [1:0]          inflight;
  logic [WIDTH-1:0]    pf_mem [PF_DEPTH];
  logic [PF_NBITS-1:0] pf_wptr;
  logic [PF_NBITS-1:0] pf_rptr;
  logic [PF_NBITS:0]   pf_cnt;
  logic [PF_NBITS+1:0] credit_used;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_nxt;
  logic                afull_q;
  logic                ovf_q;
  logic                udf_q;
  op_e                 op;

  assign bus.empty = (pf_cnt == '0);
  assign wr_acc    = bus.wr & ~bram_full & ~bus.flush;
  assign rd_acc    = bus.rd & ~bus.empty & ~bus.flush;
  assign op        = op_e'({rd_acc, wr_acc});

  // Reads still in the BRAM pipe hold a prefetch slot, so a refill racing a pop cannot overflow.
  assign credit_used = {1'b0, pf_cnt} + {{PF_NBITS{1'b0}}, inflight};
  assign issue       = ~bram_empty & ~bus.flush & (credit_used < (PF_NBITS+2)'(PF_DEPTH));

  sfifo_bram_gen #(
    .WIDTH       (WIDTH),
    .DEPTH_NBITS (DEPTH_NBITS),
    .RD_LAT      (RD_LAT)
  ) u_bram (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flush),
    .wr       (wr_acc),
    .din      (bus.din),
    .rd       (issue),
    .rdata    (bram_rdata),
    .rvalid   (pf_wr),
    .inflight (inflight),
    .full     (bram_full),
    .empty    (bram_empty)
  );

  always_comb begin
    count_nxt = count_q;
    if (bus.flush) begin
      count_nxt = '0;
    end else begin
      case (op)
        OP_PUSH: count_nxt = count_q + CNT_W'(1);
        OP_POP:  count_nxt = count_q - CNT_W'(1);
        default: count_nxt = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pf_wr) pf_mem[pf_wptr] <= bram_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_wptr <= '0;
      pf_rptr <= '0;
      pf_cnt  <= '0;
      count_q <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      afull_q <= (int'(count_nxt) >= AFULL_TH);
      if (bus.wr & bram_full & ~bus.flush) ovf_q <= 1'b1;
      if (bus.rd & bus.empty & ~bus.flush) udf_q <= 1'b1;
      // Late BRAM data arriving in the flush cycle is dropped by the pointer clear.
      if (bus.flush) begin
        pf_wptr <= '0;
        pf_rptr <= '0;
        pf_cnt  <= '0;
      end else begin
        if (pf_wr)  pf_wptr <= pf_wptr + PF_NBITS'(1);
        if (rd_acc) pf_rptr <= pf_rptr + PF_NBITS'(1);
        pf_cnt <= pf_cnt + {{PF_NBITS{1'b0}}, pf_wr} - {{PF_NBITS{1'b0}}, rd_acc};
      end
    end
  end

  assign bus.dout  = pf_mem[pf_rptr];
  assign bus.full  = bram_full;
  assign bus.afull = afull_q;
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.udf   = udf_q;

endmodule

// File: tb/tb_sfifo_bram_pf_gen.sv
// tb/tb_sfifo_bram_pf_gen.sv - bench driving RD_LAT=1 and RD_LAT=2 instances against a queue model
module tb_sfifo_bram_pf_gen;
  localparam int W     = 16;
  localparam int DN    = 4;
  localparam int PN    = 2;
  localparam int CW    = DN + PN + 1;
  localparam int TH    = 12;
  localparam int DEPTH = 16;
  localparam int PFD   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         wr = 1'b0;
  logic         rd = 1'b0;
  logic         flush = 1'b0;

  sfifo_bram_pf_gen_if #(.WIDTH(W), .CNT_W(CW)) if0 ();
  sfifo_bram_pf_gen_if #(.WIDTH(W), .CNT_W(CW)) if1 ();

  assign if0.din = din;  assign if0.wr = wr;  assign if0.rd = rd;  assign if0.flush = flush;
  assign if1.din = din;  assign if1.wr = wr;  assign if1.rd = rd;  assign if1.flush = flush;

  sfifo_bram_pf_gen #(.WIDTH(W), .DEPTH_NBITS(DN), .PF_NBITS(PN), .RD_LAT(1), .AFULL_TH(TH))
    u_lat1 (.clk(clk), .rst(rst), .bus(if0));
  sfifo_bram_pf_gen #(.WIDTH(W), .DEPTH_NBITS(DN), .PF_NBITS(PN), .RD_LAT(2), .AFULL_TH(TH))
    u_lat2 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  logic [W-1:0]  o_dout [2];
  logic [CW-1:0] o_count [2];
  logic          o_empty [2];
  logic          o_full [2];
  logic          o_afull [2];
  logic          o_ovf [2];
  logic          o_udf [2];

  assign o_dout[0]  = if0.dout;   assign o_dout[1]  = if1.dout;
  assign o_count[0] = if0.count;  assign o_count[1] = if1.count;
  assign o_empty[0] = if0.empty;  assign o_empty[1] = if1.empty;
  assign o_full[0]  = if0.full;   assign o_full[1]  = if1.full;
  assign o_afull[0] = if0.afull;  assign o_afull[1] = if1.afull;
  assign o_ovf[0]   = if0.ovf;    assign o_ovf[1]   = if1.ovf;
  assign o_udf[0]   = if0.udf;    assign o_udf[1]   = if1.udf;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a plain circular list of held values per instance.
  logic [W-1:0] mq [2][64];
  int  m_head [2];
  int  m_size [2];
  bit  m_ovf [2];
  bit  m_udf [2];
  int  stall [2];
  bit  s_full [2];
  bit  s_empty [2];
  bit  sb_on = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_head[i] = 0; m_size[i] = 0; m_ovf[i] = 1'b0; m_udf[i] = 1'b0;
      end else if (flush) begin
        m_size[i] = 0;
      end else begin
        if (wr && s_full[i])  m_ovf[i] = 1'b1;
        if (rd && s_empty[i]) m_udf[i] = 1'b1;
        if (rd && !s_empty[i] && m_size[i] > 0) begin
          m_head[i] = (m_head[i] + 1) % 64;
          m_size[i]--;
        end
        if (wr && !s_full[i]) begin
          mq[i][(m_head[i] + m_size[i]) % 64] = din;
          m_size[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      s_full[i]  = o_full[i];
      s_empty[i] = o_empty[i];
      if (sb_on && !rst) begin
        chk($sformatf("u%0d_count", i), 32'(o_count[i]), 32'(m_size[i]));
        chk($sformatf("u%0d_ovf", i), 32'(o_ovf[i]), 32'(m_ovf[i]));
        chk($sformatf("u%0d_udf", i), 32'(o_udf[i]), 32'(m_udf[i]));
        chk($sformatf("u%0d_afull", i), 32'(o_afull[i]), 32'(m_size[i] >= TH));
        if (!o_empty[i]) begin
          chk($sformatf("u%0d_has_data", i), 32'(m_size[i] > 0), 32'd1);
          chk($sformatf("u%0d_dout", i), 32'(o_dout[i]), 32'(mq[i][m_head[i]]));
        end
        if (m_size[i] == 0) chk($sformatf("u%0d_empty", i), 32'(o_empty[i]), 32'd1);
        chk($sformatf("u%0d_full_lo", i), 32'(o_full[i] && m_size[i] < DEPTH), 32'd0);
        chk($sformatf("u%0d_full_hi", i), 32'(!o_full[i] && m_size[i] >= DEPTH + PFD), 32'd0);
        stall[i] = (m_size[i] > 0 && o_empty[i]) ? stall[i] + 1 : 0;
        chk($sformatf("u%0d_stall", i), 32'(stall[i] <= i + 2), 32'd1);
      end else begin
        stall[i] = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    sb_on = 1'b0; wr = 1'b0; rd = 1'b0; flush = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_rst_count", i), 32'(o_count[i]), 32'd0);
      chk($sformatf("u%0d_rst_empty", i), 32'(o_empty[i]), 32'd1);
      chk($sformatf("u%0d_rst_full", i), 32'(o_full[i]), 32'd0);
      chk($sformatf("u%0d_rst_afull", i), 32'(o_afull[i]), 32'd0);
      chk($sformatf("u%0d_rst_flags", i), 32'({o_ovf[i], o_udf[i]}), 32'd0);
    end
    tick();
    rst = 1'b0;
    sb_on = 1'b1;
  endtask

  task automatic write_n(input int n, input logic [W-1:0] base);
    for (int k = 0; k < n; k++) begin
      din = base + W'(k); wr = 1'b1;
      tick();
    end
    wr = 1'b0;
  endtask

  task automatic drain_n(input int n, input logic [W-1:0] base, input string tag);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 2; i++)
        chk($sformatf("u%0d_%s_%0d", i, tag, k), 32'(o_dout[i]), 32'(base + W'(k)));
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
  endtask

  int bub [2];
  int drift [2];

  initial begin
    do_reset();

    // Three writes into an empty FIFO: show-ahead latency is 2+RD_LAT.
    din = 16'h000A; wr = 1'b1; tick();
    chk("lat1_empty_c1", 32'(o_empty[0]), 32'd1);
    chk("count_c1", 32'(o_count[0]), 32'd1);
    din = 16'h000B; tick();
    chk("lat1_empty_c2", 32'(o_empty[0]), 32'd1);
    din = 16'h000C; tick();
    wr = 1'b0;
    chk("lat1_empty_c3", 32'(o_empty[0]), 32'd0);
    chk("lat1_dout_c3", 32'(o_dout[0]), 32'h000A);
    chk("lat2_empty_c3", 32'(o_empty[1]), 32'd1);
    tick();
    chk("lat2_empty_c4", 32'(o_empty[1]), 32'd0);
    chk("lat2_dout_c4", 32'(o_dout[1]), 32'h000A);
    for (int i = 0; i < 2; i++) chk($sformatf("u%0d_count3", i), 32'(o_count[i]), 32'd3);
    drain_n(3, 16'h000A, "abc");
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_abc_count0", i), 32'(o_count[i]), 32'd0);
      chk($sformatf("u%0d_abc_empty", i), 32'(o_empty[i]), 32'd1);
    end

    // Underflow after draining eight entries.
    do_reset();
    write_n(8, 16'h0200);
    repeat (6) tick();
    drain_n(8, 16'h0200, "u8");
    rd = 1'b1; tick(); rd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_udf_set", i), 32'(o_udf[i]), 32'd1);
      chk($sformatf("u%0d_udf_count", i), 32'(o_count[i]), 32'd0);
      chk($sformatf("u%0d_udf_empty", i), 32'(o_empty[i]), 32'd1);
    end

    // Fill BRAM plus prefetch, then overflow.
    do_reset();
    write_n(20, 16'h0100);
    repeat (6) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_fill_full", i), 32'(o_full[i]), 32'd1);
      chk($sformatf("u%0d_fill_count", i), 32'(o_count[i]), 32'd20);
      chk($sformatf("u%0d_fill_afull", i), 32'(o_afull[i]), 32'd1);
      chk($sformatf("u%0d_fill_ovf0", i), 32'(o_ovf[i]), 32'd0);
    end
    din = 16'hDEAD; wr = 1'b1; tick(); wr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_ovf_set", i), 32'(o_ovf[i]), 32'd1);
      chk($sformatf("u%0d_ovf_count", i), 32'(o_count[i]), 32'd20);
    end
    drain_n(20, 16'h0100, "full");
    for (int i = 0; i < 2; i++) chk($sformatf("u%0d_full_drained", i), 32'(o_empty[i]), 32'd1);

    // Flush while two BRAM reads are in flight (RD_LAT=2 instance).
    do_reset();
    write_n(2, 16'h0031);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_flush_count", i), 32'(o_count[i]), 32'd0);
      chk($sformatf("u%0d_flush_empty", i), 32'(o_empty[i]), 32'd1);
    end
    repeat (6) begin
      tick();
      for (int i = 0; i < 2; i++) chk($sformatf("u%0d_flush_quiet", i), 32'(o_empty[i]), 32'd1);
    end
    write_n(1, 16'h0055);
    repeat (5) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_post_flush_dout", i), 32'(o_dout[i]), 32'h0055);
      chk($sformatf("u%0d_post_flush_count", i), 32'(o_count[i]), 32'd1);
    end
    rd = 1'b1; tick(); rd = 1'b0;

    // Reset in the middle of a stream holding seven entries.
    write_n(7, 16'h0700);
    repeat (2) tick();
    for (int i = 0; i < 2; i++) chk($sformatf("u%0d_pre_rst_count", i), 32'(o_count[i]), 32'd7);
    do_reset();
    write_n(1, 16'h0077);
    repeat (5) tick();
    for (int i = 0; i < 2; i++) chk($sformatf("u%0d_post_rst_dout", i), 32'(o_dout[i]), 32'h0077);
    rd = 1'b1; tick(); rd = 1'b0;
    for (int i = 0; i < 2; i++) chk($sformatf("u%0d_post_rst_count", i), 32'(o_count[i]), 32'd0);

    // Continuous write+read after priming: no bubbles, constant count.
    do_reset();
    write_n(6, 16'h1000);
    repeat (8) tick();
    bub[0] = 0; bub[1] = 0; drift[0] = 0; drift[1] = 0;
    for (int c = 0; c < 1000; c++) begin
      din = 16'h2000 + W'(c); wr = 1'b1; rd = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
        if (o_empty[i]) bub[i]++;
        if (o_count[i] != CW'(6)) drift[i]++;
      end
    end
    wr = 1'b0; rd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_stream_bubbles", i), 32'(bub[i]), 32'd0);
      chk($sformatf("u%0d_stream_drift", i), 32'(drift[i]), 32'd0);
    end

    // Randomized traffic with alternating fill/drain bias and rare flushes.
    for (int c = 0; c < 4000; c++) begin
      int wp;
      int rp;
      wp = ((c / 500) % 2 == 0) ? 70 : 35;
      rp = ((c / 500) % 2 == 0) ? 35 : 70;
      din   = W'($urandom);
      wr    = ($urandom_range(0, 99) < wp);
      rd    = ($urandom_range(0, 99) < rp);
      flush = ($urandom_range(0, 199) == 0);
      tick();
    end
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sfifo_bram_pf_gen.md
SFIFO_BRAM_PF_GEN -- requirements
Module: sfifo_bram_pf_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 64, payload bits per entry.
REQ-002 SHALL have parameter DEPTH_NBITS, default 12, log2 of BRAM entries; DEPTH = 1<<DEPTH_NBITS.
REQ-003 SHALL have parameter PF_NBITS, default 2, log2 of prefetch stage entries; PF_DEPTH = 1<<PF_NBITS, minimum 4.
REQ-004 SHALL have parameter RD_LAT, default 1, BRAM read latency in cycles, legal values 1 or 2.
REQ-005 SHALL have parameter AFULL_TH, default DEPTH-16, almost-full threshold on count.
REQ-006 Ports:
  clk  in  1  single clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  din  in  WIDTH  write data.
  wr  in  1  write request.
  rd  in  1  read request; pops dout.
  flush  in  1  synchronous clear of all contents.
  dout  out  WIDTH  head entry, valid whenever empty=0 (show-ahead).
  empty  out  1  no entry available at dout.
  full  out  1  BRAM store full; writes are dropped.
  afull  out  1  count >= AFULL_TH.
  count  out  DEPTH_NBITS+PF_NBITS+1  total entries held (BRAM + in-flight + prefetch).
  ovf  out  1  sticky: write attempted while full.
  udf  out  1  sticky: read attempted while empty.

Function
REQ-007 Accepted write = wr & ~full & ~flush; accepted read = rd & ~empty & ~flush.
REQ-008 count SHALL update next cycle: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither; never wraps.
REQ-009 Write while full SHALL be dropped, data unchanged, ovf set next cycle.
REQ-010 Read while empty SHALL be ignored, udf set next cycle.
REQ-011 Internal BRAM read SHALL issue only when BRAM non-empty and (prefetch occupancy + reads in flight) < PF_DEPTH.
REQ-012 Read data SHALL enter the prefetch stage exactly RD_LAT cycles after issue, via a RD_LAT-deep valid pipe.
REQ-013 Credit check SHALL count reads in flight, so the prefetch stage never overflows, including under concurrent rd and refill.
REQ-014 Write into an empty block at cycle 0 SHALL clear empty at cycle 2+RD_LAT (cycle 3 for RD_LAT=1).
REQ-015 Once primed, SHALL sustain one read per cycle with no bubbles while BRAM data remains.
REQ-016 Order SHALL be strict FIFO across BRAM and prefetch stage, including BRAM pointer wrap at DEPTH.
REQ-017 Simultaneous write and read at count=1 SHALL be legal, with count staying 1 and the new data following.
REQ-018 flush SHALL take priority over wr and rd, clear pointers, the prefetch stage and the in-flight valid pipe (discarding late BRAM data), and set count=0 and empty=1 next cycle.
REQ-019 flush SHALL NOT clear ovf or udf.
REQ-020 full SHALL derive from BRAM occupancy = DEPTH; afull SHALL be registered from the next count value.

Reset
REQ-021 On rst SHALL set count=0, empty=1, full=0, afull=0, ovf=0, udf=0, pointers=0 and the in-flight pipe clear.
REQ-022 dout SHALL be don't-care while empty; BRAM contents SHALL NOT be reset.
REQ-023 rst asserted mid-traffic SHALL abandon all entries; the first write after release SHALL behave per REQ-014.

Structure
REQ-024 Payload typedefs (e.g. enq_pkt_desc_type) SHALL remain in meta_package, and instances SHALL set WIDTH = $bits(type).
REQ-025 There SHALL be no new package constants; RD_LAT and threshold defaults SHALL be module parameters only.
REQ-026 The block SHALL instantiate one sub-module, sfifo_bram_gen (WIDTH, DEPTH_NBITS, RD_LAT), with the prefetch stage as inline flops or registers.

Verification
REQ-027 Reset, then 3 writes 0xA,0xB,0xC at RD_LAT=1 -> empty=0 at cycle 3 after the first wr, dout=0xA, and reads return A,B,C with count 3->0.
REQ-028 Fill DEPTH=16 and PF=4 with 20 writes and no reads -> full=1, count=20, a 21st wr sets ovf=1 and count stays 20.
REQ-029 Continuous wr&rd for 1000 cycles, RD_LAT=2 -> zero bubbles after priming, data sequence intact, count constant.
REQ-030 Fill with 8 entries and read until empty, then 1 extra rd -> udf=1, count=0, empty=1.
REQ-031 Flush with 2 BRAM reads in flight -> next cycle count=0 and empty=1, the late data never appears, and a subsequent write 0x55 reads back 0x55.
REQ-032 rst pulse mid-stream at count=7 -> all outputs at reset values; the next write/read round-trip is correct.
